// File: rtl/eth_rx_dst_filter.sv
// eth_rx_dst_filter
// Receive-side destination MAC filter in the MAC rx clock domain. The first
// six bytes of each frame are held in a small FIFO until the destination
// address is known; matching frames are then released unchanged, while
// non-matching and runt frames are discarded by rewinding the write pointer.
// There is no backpressure on either side.
//
// Optional feature macro: ETH_RX_FILTER_STATS_EN (adds saturating frame
// counters with a synchronous clear).
//
// Ports:
//   clk, rst_n            MAC receive clock, asynchronous active-low reset
//   s_axis_t*             byte stream from the MAC (tuser = bad frame, last beat)
//   m_axis_t*             filtered byte stream
//   cfg_mac_addr          station address, [47:40] is the first byte on the wire
//   cfg_promisc           accept every frame of 7 bytes or more
//   drop_frame            one-cycle pulse per discarded frame
//   stat_clear            (stats build) synchronous clear of all counters
//   stat_*_count          (stats build) passed / dropped / runt frame counters
module eth_rx_dst_filter #(
  parameter bit PASS_BROADCAST = 1'b1,
  parameter bit PASS_MULTICAST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] cfg_mac_addr,
  input  logic        cfg_promisc,
  output logic        drop_frame
`ifdef ETH_RX_FILTER_STATS_EN
  ,
  input  logic        stat_clear,
  output logic [31:0] stat_pass_count,
  output logic [31:0] stat_drop_count,
  output logic [31:0] stat_runt_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PASS,
    S_DROP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // 3-bit index plus wrap bit so that full and empty are distinguishable
  logic [3:0]  wr_ptr;
  logic [3:0]  wr_ptr_nxt;
  logic [3:0]  rd_ptr;
  logic [3:0]  frame_ptr;
  logic [3:0]  frame_ptr_nxt;
  logic [3:0]  commit_ptr;
  logic [3:0]  commit_ptr_nxt;
  logic [2:0]  hdr_cnt;
  logic [2:0]  hdr_cnt_nxt;

  logic [9:0]  mem [8];
  logic [47:0] dst;
  logic [47:0] dst_cur;
  logic        hit;
  logic        mem_we;
  logic        dst_shift;
  logic        drop_evt;
  logic        runt_evt;
`ifdef ETH_RX_FILTER_STATS_EN
  logic        pass_evt;
`endif

  // The decision beat is compared together with the five bytes already held
  assign dst_cur = {dst[39:0], s_axis_tdata};
  assign hit     = cfg_promisc
                || (dst_cur == cfg_mac_addr)
                || (PASS_BROADCAST && (dst_cur == 48'hFFFF_FFFF_FFFF))
                || (PASS_MULTICAST && dst_cur[40]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    frame_ptr_nxt  = frame_ptr;
    commit_ptr_nxt = commit_ptr;
    hdr_cnt_nxt    = hdr_cnt;
    mem_we         = 1'b0;
    dst_shift      = 1'b0;
    drop_evt       = 1'b0;
    runt_evt       = 1'b0;
`ifdef ETH_RX_FILTER_STATS_EN
    pass_evt       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (s_axis_tvalid) begin
          mem_we        = 1'b1;
          dst_shift     = 1'b1;
          frame_ptr_nxt = wr_ptr;
          if (s_axis_tlast) begin
            // single-byte frame: leave wr_ptr where it was
            runt_evt = 1'b1;
          end else begin
            wr_ptr_nxt  = wr_ptr + 4'd1;
            hdr_cnt_nxt = 3'd1;
            state_nxt   = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (s_axis_tvalid) begin
          mem_we    = 1'b1;
          dst_shift = 1'b1;
          if (s_axis_tlast) begin
            runt_evt   = 1'b1;
            wr_ptr_nxt = frame_ptr;
            state_nxt  = S_IDLE;
          end else if (hdr_cnt == 3'd5) begin
            if (hit) begin
              wr_ptr_nxt     = wr_ptr + 4'd1;
              commit_ptr_nxt = wr_ptr + 4'd1;
              state_nxt      = S_PASS;
`ifdef ETH_RX_FILTER_STATS_EN
              pass_evt       = 1'b1;
`endif
            end else begin
              drop_evt   = 1'b1;
              wr_ptr_nxt = frame_ptr;
              state_nxt  = S_DROP;
            end
          end else begin
            wr_ptr_nxt  = wr_ptr + 4'd1;
            hdr_cnt_nxt = hdr_cnt + 3'd1;
          end
        end
      end
      S_PASS: begin
        if (s_axis_tvalid) begin
          mem_we         = 1'b1;
          wr_ptr_nxt     = wr_ptr + 4'd1;
          commit_ptr_nxt = wr_ptr + 4'd1;
          if (s_axis_tlast) begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Write side control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 4'd0;
      frame_ptr  <= 4'd0;
      commit_ptr <= 4'd0;
      hdr_cnt    <= 3'd0;
      drop_frame <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      frame_ptr  <= frame_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      hdr_cnt    <= hdr_cnt_nxt;
      drop_frame <= drop_evt | runt_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[2:0]] <= {s_axis_tdata, s_axis_tlast, s_axis_tuser};
    end
    if (dst_shift) begin
      dst <= dst_cur;
    end
  end

  // Read side: drain committed beats, one per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= 4'd0;
      m_axis_tdata  <= 8'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (rd_ptr != commit_ptr) begin
      {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= mem[rd_ptr[2:0]];
      m_axis_tvalid <= 1'b1;
      rd_ptr        <= rd_ptr + 4'd1;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && mem_we) begin
      assert ((wr_ptr - rd_ptr) != 4'd8)
        else $error("eth_rx_dst_filter: write into full FIFO");
    end
  end
`endif

`ifdef ETH_RX_FILTER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    if (inc && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pass_count <= 32'd0;
      stat_drop_count <= 32'd0;
      stat_runt_count <= 32'd0;
    end else if (stat_clear) begin
      stat_pass_count <= 32'd0;
      stat_drop_count <= 32'd0;
      stat_runt_count <= 32'd0;
    end else begin
      stat_pass_count <= sat_inc(stat_pass_count, pass_evt);
      stat_drop_count <= sat_inc(stat_drop_count, drop_evt);
      stat_runt_count <= sat_inc(stat_runt_count, runt_evt);
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_dst_filter.sv
// Testbench for eth_rx_dst_filter: directed scenarios plus randomized frames,
// checked against a frame-level reference model (length, destination rules,
// expected byte stream and drop/pass/runt counts).
module tb_eth_rx_dst_filter;

  localparam bit          PB      = 1'b1;
  localparam bit          PM      = 1'b0;
  localparam logic [47:0] STATION = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [47:0] cfg_mac_addr = STATION;
  logic        cfg_promisc = 1'b0;
  logic        drop_frame;
`ifdef ETH_RX_FILTER_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_pass_count;
  logic [31:0] stat_drop_count;
  logic [31:0] stat_runt_count;
`endif

  always #5 clk = ~clk;

  eth_rx_dst_filter #(
    .PASS_BROADCAST(PB),
    .PASS_MULTICAST(PM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .cfg_mac_addr(cfg_mac_addr),
    .cfg_promisc(cfg_promisc),
    .drop_frame(drop_frame)
`ifdef ETH_RX_FILTER_STATS_EN
    ,
    .stat_clear(stat_clear),
    .stat_pass_count(stat_pass_count),
    .stat_drop_count(stat_drop_count),
    .stat_runt_count(stat_runt_count)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor (sole writer of obs_*)
  logic [9:0] obs_q[$];
  int         obs_cyc[$];
  int         obs_drops = 0;
  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      obs_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
      obs_cyc.push_back(cyc);
    end
    if (drop_frame) obs_drops++;
  end

  int errors = 0;
  int checks = 0;

  logic [7:0] fbytes[$];
  int         in_cyc[$];
  logic [9:0] exp_q[$];
  int         obs_base = 0;
  int         drop_base = 0;
  int         exp_drops = 0;
  int         m_pass = 0;
  int         m_drop = 0;
  int         m_runt = 0;
  logic       promisc_after = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: decide a frame from its length and destination address
  function automatic void model_frame(input int first, input bit tu, input bit promisc,
                                      input logic [47:0] mac);
    int          n;
    logic [47:0] d;
    bit          acc;
    n = fbytes.size() - first;
    if (n < 7) begin
      m_runt++;
      exp_drops++;
      return;
    end
    d = {fbytes[first], fbytes[first+1], fbytes[first+2],
         fbytes[first+3], fbytes[first+4], fbytes[first+5]};
    acc = promisc || (d == mac) || (PB && d == 48'hFFFF_FFFF_FFFF) || (PM && d[40]);
    if (acc) begin
      m_pass++;
      for (int i = first; i < fbytes.size(); i++) begin
        exp_q.push_back({fbytes[i], (i == fbytes.size() - 1),
                         tu && (i == fbytes.size() - 1)});
      end
    end else begin
      m_drop++;
      exp_drops++;
    end
  endfunction

  task automatic mk_frame(input logic [47:0] d, input int len);
    fbytes.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) fbytes.push_back(d[47-8*i -: 8]);
      else       fbytes.push_back(8'($urandom));
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle between beats, 2 random idles
  task automatic send(input int first, input int last_idx, input bit tu, input int gap_mode);
    int g;
    for (int i = first; i <= last_idx; i++) begin
      g = 0;
      if (i != first) begin
        if (gap_mode == 1) g = 1;
        else if (gap_mode == 2) g = $urandom_range(0, 2);
      end
      repeat (g) begin
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
      end
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fbytes[i];
      s_axis_tlast  = (i == fbytes.size() - 1);
      s_axis_tuser  = tu && (i == fbytes.size() - 1);
      in_cyc.push_back(cyc);
      if (i - first == 6) cfg_promisc = promisc_after;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
  endtask

  task automatic compare_stream(input string tag);
    int n_obs;
    n_obs = obs_q.size() - obs_base;
    check({tag, "_len"}, n_obs, exp_q.size());
    for (int i = 0; i < n_obs && i < exp_q.size(); i++) begin
      check({tag, "_beat"}, obs_q[obs_base+i], exp_q[i]);
    end
    exp_q.delete();
    obs_base = obs_q.size();
    check({tag, "_drops"}, obs_drops - drop_base, exp_drops);
    drop_base = obs_drops;
    exp_drops = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef ETH_RX_FILTER_STATS_EN
    check({tag, "_pass_cnt"}, stat_pass_count, m_pass);
    check({tag, "_drop_cnt"}, stat_drop_count, m_drop);
    check({tag, "_runt_cnt"}, stat_runt_count, m_runt);
`else
    if (tag.len() < 0) checks++;
`endif
  endtask

  task automatic send_model(input logic [47:0] d, input int len, input bit tu, input int gap);
    mk_frame(d, len);
    promisc_after = cfg_promisc;
    model_frame(0, tu, cfg_promisc, cfg_mac_addr);
    send(0, len - 1, tu, gap);
  endtask

  initial begin
    logic [47:0] d;
    logic [63:0] r;
    int          len;
    int          kind;
    bit          tu;
    bit          pr;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tuser", m_axis_tuser, 1'b0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check("rst_drop", drop_frame, 1'b0);
    check_stats("rst");
    rst_n = 1'b1;
    idle(2);

    // Unicast match, 64 bytes back-to-back, fixed 7-cycle latency
    in_cyc.delete();
    send_model(STATION, 64, 1'b0, 0);
    idle(12);
    check("uni_cnt", obs_q.size() - obs_base, 64);
    for (int i = 0; i < 64 && (obs_base + i) < obs_q.size(); i++) begin
      check("uni_latency", obs_cyc[obs_base+i] - in_cyc[i], 7);
    end
    compare_stream("unicast");
    check_stats("unicast");

    // Mismatch dropped, following matching frame intact
    send_model(48'h02_00_00_00_00_02, 64, 1'b0, 0);
    send_model(STATION, 64, 1'b0, 0);
    idle(12);
    compare_stream("mismatch");

    // Broadcast passes, multicast dropped; promiscuous passes both
    send_model(48'hFF_FF_FF_FF_FF_FF, 20, 1'b0, 0);
    send_model(48'h01_00_5E_00_00_01, 20, 1'b0, 0);
    idle(12);
    compare_stream("bc_mc");
    cfg_promisc = 1'b1;
    send_model(48'hFF_FF_FF_FF_FF_FF, 20, 1'b0, 0);
    send_model(48'h01_00_5E_00_00_01, 20, 1'b0, 0);
    idle(12);
    compare_stream("bc_mc_promisc");

    // Runts (4 and 6 bytes) dropped even when promiscuous; 7 bytes pass
    send_model(48'h02_00_00_00_00_01, 4, 1'b0, 0);
    idle(2);
    send_model(48'h02_00_00_00_00_01, 6, 1'b0, 0);
    idle(2);
    send_model(48'h12_34_56_78_9A_BC, 7, 1'b0, 0);
    idle(12);
    compare_stream("runt");
    check_stats("runt");
    cfg_promisc = 1'b0;

    // Bad frame then matching frame, input valid every other cycle
    send_model(STATION, 30, 1'b1, 1);
    idle(1);
    send_model(STATION, 25, 1'b0, 1);
    idle(12);
    compare_stream("badfcs");

`ifdef ETH_RX_FILTER_STATS_EN
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    m_pass = 0;
    m_drop = 0;
    m_runt = 0;
    check_stats("clear");
`endif

    // Randomized frames; promisc may flip after the decision beat
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      r    = {$urandom, $urandom};
      case (kind)
        0:       d = STATION;
        1:       d = 48'hFF_FF_FF_FF_FF_FF;
        2:       d = 48'h01_00_5E_00_00_00 | 48'($urandom_range(0, 255));
        default: d = r[47:0];
      endcase
      len = $urandom_range(1, 24);
      tu  = 1'($urandom_range(0, 1));
      pr  = ($urandom_range(0, 3) == 0);
      cfg_promisc = pr;
      mk_frame(d, len);
      model_frame(0, tu, pr, cfg_mac_addr);
      promisc_after = 1'($urandom_range(0, 1));
      send(0, len - 1, tu, $urandom_range(0, 2));
      idle($urandom_range(0, 2));
    end
    idle(15);
    compare_stream("random");
    check_stats("random");

    // Reset in the middle of a passing frame
    cfg_promisc = 1'b0;
    mk_frame(STATION, 64);
    promisc_after = 1'b0;
    send(0, 19, 1'b0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #1;
    check("rstmid_tvalid", m_axis_tvalid, 1'b0);
    m_pass = 0;
    m_drop = 0;
    m_runt = 0;
    check_stats("rstmid");
    exp_q.delete();
    exp_drops = 0;
    drop_base = obs_drops;
    obs_base  = obs_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    // the rest of the interrupted frame is seen as a new frame
    model_frame(20, 1'b0, 1'b0, cfg_mac_addr);
    send(20, 63, 1'b0, 0);
    send_model(STATION, 40, 1'b0, 0);
    idle(12);
    compare_stream("after_reset");
    check_stats("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_dst_filter.md
# eth_rx_dst_filter

Receive-side destination-address filter that sits directly downstream of the 1G MAC receive AXI-stream output, in the MAC `rx_clk` domain. It buffers the first six bytes of each frame, compares the destination MAC address against the station address, broadcast and multicast rules, and then either forwards the whole frame unchanged or discards it without trace. Like the MAC, its input and output have no backpressure (no `tready`).

## Interface
Parameters:
- `PASS_BROADCAST`, 1: accept destination FF:FF:FF:FF:FF:FF.
- `PASS_MULTICAST`, 0: accept any destination whose first byte has bit 0 set.

Ports:
- `clk` in 1: MAC receive clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `s_axis_tdata` in 8, `s_axis_tvalid` in 1, `s_axis_tlast` in 1, `s_axis_tuser` in 1: frame from the MAC; `tuser` marks a bad frame on the last beat.
- `m_axis_tdata` out 8, `m_axis_tvalid` out 1, `m_axis_tlast` out 1, `m_axis_tuser` out 1: filtered frame.
- `cfg_mac_addr` in 48: station address; `[47:40]` is the first byte on the wire.
- `cfg_promisc` in 1: accept every frame of 7 bytes or more.
- `drop_frame` out 1: one-cycle pulse per discarded frame.
- Only with `ETH_RX_FILTER_STATS_EN`:
  - `stat_clear` in 1: synchronous counter clear.
  - `stat_pass_count` out 32, `stat_drop_count` out 32, `stat_runt_count` out 32: frame counters.

## Operation
- Storage is an 8-entry FIFO of {tdata, tlast, tuser}, with 3-bit pointers plus a wrap bit.
- Pointers:
  - `wr_ptr` is the write pointer.
  - `rd_ptr` is the read pointer.
  - `frame_ptr` holds the start of the current frame.
  - `commit_ptr` is the boundary the read side may not pass.
- Write-side states:
  - IDLE: the first valid beat is written, `frame_ptr` is set to the old `wr_ptr`, and the state moves to HEADER with `hdr_cnt=1`.
  - HEADER: every valid beat is written and `hdr_cnt` increments. Bytes are also shifted into a 48-bit `dst` register, first byte MSB.
  - PASS: every valid beat is written and `commit_ptr` is set to `wr_ptr+1`. A beat with tlast returns the state to IDLE.
  - DROP: valid beats are ignored. A beat with tlast returns the state to IDLE.
- Runt frame: tlast on beats 1..6.
  - `wr_ptr` rolls back to `frame_ptr` and `drop_frame` pulses.
  - The runt counter increments and the state returns to IDLE.
  - A runt frame is never forwarded, even in promiscuous mode.
- Decision: made on the 6th beat when it has no tlast. The match term is `cfg_promisc | (dst==cfg_mac_addr) | (PASS_BROADCAST & dst==48'hFFFFFFFFFFFF) | (PASS_MULTICAST & dst[40])`.
  - Match: `commit_ptr` is set to `wr_ptr+1` (the 6th beat is included), the state moves to PASS, and the pass counter increments.
  - No match: `wr_ptr` rolls back to `frame_ptr`, the state moves to DROP, `drop_frame` pulses and the drop counter increments.
- `cfg_*` inputs are sampled only on the decision beat. Changes mid-frame do not affect the frame in flight.
- Read side: a beat is popped whenever `rd_ptr != commit_ptr`, at most one per cycle, and the popped entry is registered onto `m_axis_*`. Otherwise `m_axis_tvalid` is 0.
- A frame with tuser=1 that reached PASS is forwarded with `m_axis_tuser=1` on its last beat. It is not counted as dropped.
- Overflow cannot occur:
  - Input rate is at most 1 beat/cycle and output drains at 1 beat/cycle once committed.
  - Peak occupancy is 6 header beats plus 1.
  - Requirement: an assertion (simulation only) flags a write when the FIFO is full.
- The next frame's header may be written behind the previous frame's draining tail. The read side stops at `commit_ptr` until that header is decided.

## Timing
- Reset values: `m_axis_tvalid`, `tlast`, `tuser` = 0 and `m_axis_tdata` = 0. `drop_frame` = 0, all pointers = 0, state = IDLE, counters = 0.
- Latency:
  - Header byte 0 appears on `m_axis` 1 cycle after the decision edge. Header byte k appears k cycles later.
  - In PASS with back-to-back input, every byte leaves exactly 7 cycles after it was accepted.
- `drop_frame` asserts in the cycle after the decision or runt beat, for exactly 1 cycle.
- Reset mid-frame: everything clears asynchronously. A partial frame on `m_axis` is truncated with no tlast. After release, the block restarts in IDLE and the remainder of an in-flight input frame is treated as a new frame.
- Input gaps (MII mode, `tvalid` low) are preserved only as idle cycles on the output. Ordering and content are unchanged.

## Configuration
- `ETH_RX_FILTER_STATS_EN` defined:
  - `stat_clear`, `stat_pass_count`, `stat_drop_count` and `stat_runt_count` exist.
  - Counters are 32-bit, saturate at FFFFFFFF, and clear the cycle after `stat_clear`.
  - If clear and increment coincide, clear wins.
- Not defined: those ports and counter logic are absent. Filtering behaviour is identical.

## Test plan
- Unicast match: `cfg_mac_addr`=02:00:00:00:00:01, 64-byte frame to that address, back-to-back -> all 64 bytes out unchanged, tlast on byte 63, byte 0 out 1 cycle after the 6th input byte, pass=1.
- Mismatch drop: same config, frame to 02:00:00:00:00:02 -> no `m_axis_tvalid`, `drop_frame` one pulse, drop=1. The following matching frame is forwarded intact.
- Broadcast/multicast: frames to FF:FF:FF:FF:FF:FF and 01:00:5E:00:00:01 with defaults -> broadcast forwarded, multicast dropped. With `cfg_promisc`=1 both are forwarded.
- Runt: 4-byte frame with tlast on byte 4, `cfg_promisc`=1 -> dropped, runt=1, `drop_frame` pulse. A 7-byte frame is forwarded.
- Bad FCS plus back-to-back: a matching frame ending with tuser=1, followed 1 cycle later by a matching frame, input tvalid toggled every other cycle -> both forwarded in order, tuser=1 only on the first frame's last beat, no overflow.
- Reset: assert `rst_n` low mid-PASS -> `m_axis_tvalid` is 0 immediately and counters are 0. The next full matching frame passes.
